// File: rtl/pll_reset_seq.sv
// Startup/reset sequencer behind the board PLL: debounces lock, releases the PSRAM
// reset then the video reset, re-sequences on lock loss and pulses the PLL reset on timeout.
module pll_reset_seq #(
    parameter int unsigned LOCK_STABLE   = 1024,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned PLL_RST_LEN   = 32,
    parameter int unsigned CALIB_TIMEOUT = 262144,
    parameter int unsigned CNT_W         = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       psram_calib_done,
    output logic       pll_reset,
    output logic       psram_rst_n,
    output logic       video_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABLE     = 3'd1,
        WAIT_GAP   = 3'd2,
        WAIT_CALIB = 3'd3,
        RUN        = 3'd4,
        PLL_RST    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_LEN - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST   = CNT_W'(CALIB_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             lk_meta, lk, cd_meta, cd;
    logic             loss;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
            cd_meta <= 1'b0;
            cd      <= 1'b0;
        end else begin
            lk_meta <= pll_lock;
            lk      <= lk_meta;
            cd_meta <= psram_calib_done;
            cd      <= cd_meta;
        end
    end

    // Lock loss is checked first in every accepted state so it beats calib-done and timeouts.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        loss     = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lk) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx = PLL_RST;
                    cnt_nx   = '0;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = WAIT_GAP;
                    cnt_nx   = '0;
                end
            end
            WAIT_GAP: begin
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                    loss     = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    state_nx = WAIT_CALIB;
                    cnt_nx   = '0;
                end
            end
            WAIT_CALIB: begin
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                    loss     = 1'b1;
                end else if (cd) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else if (cnt == CALIB_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lk) begin
                    state_nx = WAIT_LOCK;
                    loss     = 1'b1;
                end
            end
            PLL_RST: begin
                if (cnt == PLLRST_LAST) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            pll_reset     <= 1'b0;
            psram_rst_n   <= 1'b0;
            video_rst_n   <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pll_reset   <= (state_nx == PLL_RST);
            psram_rst_n <= (state_nx == WAIT_GAP) || (state_nx == WAIT_CALIB) || (state_nx == RUN);
            video_rst_n <= (state_nx == RUN);
            ready       <= (state_nx == RUN);
            if (loss && (lock_loss_cnt != 8'hFF))
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end

    assign state_o = state;

endmodule
